// File: rtl/z_result_stage_pkg.sv
// rtl/z_result_stage_pkg.sv - opcodes, FSM state encoding and helpers for the ALU result stage
//   opc_t        : 5-bit opcode field, matching the ALU opcode encoding
//   OP_*         : opcodes the result stage treats specially
//   state_t      : write-back FSM state
//   is_two_word  : 1 for opcodes whose 64-bit result is returned as LO then HI
package z_result_stage_pkg;

  typedef logic [4:0] opc_t;

  localparam opc_t OP_MUL  = 5'b01110;
  localparam opc_t OP_DIV  = 5'b01111;
  localparam opc_t OP_MFHI = 5'b10111;
  localparam opc_t OP_MFLO = 5'b11000;
  localparam opc_t OP_NOP  = 5'b11001;
  localparam opc_t OP_HALT = 5'b11010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WB_LO = 2'd1,
    ST_WB_HI = 2'd2
  } state_t;

  function automatic logic is_two_word(input opc_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/z_result_stage_if.sv
// rtl/z_result_stage_if.sv - capture strobe and result-word handshake between ALU, result stage and bus
//   z_in/c_in/opcode : capture side, driven upstream; busy returned by the stage
//   out_valid/out_data/out_is_hi : result word from the stage; out_ready from the consumer
//   modport slave  : the result stage
//   modport master : the surrounding datapath (upstream ALU and downstream consumer)
interface z_result_stage_if #(
  parameter int DATA_W = 32,
  parameter int OPC_W  = 5
);
  logic                  z_in;
  logic [2*DATA_W-1:0]   c_in;
  logic [OPC_W-1:0]      opcode;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_data;
  logic                  out_is_hi;

  modport slave (
    input  z_in, c_in, opcode, out_ready,
    output busy, out_valid, out_data, out_is_hi
  );

  modport master (
    output z_in, c_in, opcode, out_ready,
    input  busy, out_valid, out_data, out_is_hi
  );
endinterface

// File: rtl/z_result_stage_hilo_regs.sv
// rtl/z_result_stage_hilo_regs.sv - architectural HI/LO register pair
//   clk, rst_n : clock and asynchronous active-low reset (loads RST_VAL into both)
//   we         : write HI and LO together
//   hi_d, lo_d : new HI/LO values
//   hi_q, lo_q : current HI/LO values
module hilo_regs #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] hi_d,
  input  logic [DATA_W-1:0] lo_d,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= RST_VAL;
      lo_q <= RST_VAL;
    end else if (we) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/z_result_stage.sv
// rtl/z_result_stage.sv - captures the ALU result and returns it to the bus as 32-bit words
//   clk        : clock, rising edge
//   clear      : asynchronous reset, active-low
//   bus        : capture strobe/result and out_valid/out_ready word handshake (slave side)
//   hi_out     : HI register, lo_out : LO register
//   flag_zero, flag_neg : registered result flags, built only when Z_FLAGS_EN is defined
//                         (constant 0 otherwise)
module z_result_stage
  import z_result_stage_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                OPC_W    = 5,
  parameter logic [DATA_W-1:0] HILO_RST = '0
) (
  input  logic              clk,
  input  logic              clear,
  z_result_stage_if.slave   bus,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              flag_zero,
  output logic              flag_neg
);

  state_t            state;
  logic              two_word;
  logic [DATA_W-1:0] zhi;
  logic [DATA_W-1:0] zlo_next;
  opc_t              op;
  logic              final_word;
  logic              accept;
  logic              capture;
  logic              cap_two;
  logic              retire;

  assign op = opc_t'(bus.opcode);

  // The word on the bus is the last one of its result: either a single-word
  // result in WB_LO or the HI half of a mul/div.
  assign final_word = ((state == ST_WB_LO) && !two_word) || (state == ST_WB_HI);

  // Combinational in out_ready so a new result can be taken on the very edge
  // the last word retires, keeping the output stream gap-free.
  assign bus.busy = !((state == ST_IDLE) || (final_word && bus.out_ready));

  assign accept  = bus.z_in && !bus.busy;
  assign capture = accept && (op != OP_NOP) && (op != OP_HALT);
  assign cap_two = is_two_word(op);
  assign retire  = bus.out_valid && bus.out_ready;

  always_comb begin
    zlo_next = bus.c_in[DATA_W-1:0];
    if (op == OP_MFHI) begin
      zlo_next = hi_out;
    end else if (op == OP_MFLO) begin
      zlo_next = lo_out;
    end
  end

  hilo_regs #(
    .DATA_W  (DATA_W),
    .RST_VAL (HILO_RST)
  ) u_hilo (
    .clk   (clk),
    .rst_n (clear),
    .we    (capture && cap_two),
    .hi_d  (bus.c_in[2*DATA_W-1:DATA_W]),
    .lo_d  (bus.c_in[DATA_W-1:0]),
    .hi_q  (hi_out),
    .lo_q  (lo_out)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state         <= ST_IDLE;
      two_word      <= 1'b0;
      zhi           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_is_hi <= 1'b0;
    end else if (capture) begin
      state         <= ST_WB_LO;
      two_word      <= cap_two;
      zhi           <= bus.c_in[2*DATA_W-1:DATA_W];
      bus.out_valid <= 1'b1;
      bus.out_data  <= zlo_next;
      bus.out_is_hi <= 1'b0;
    end else if (retire) begin
      if ((state == ST_WB_LO) && two_word) begin
        state         <= ST_WB_HI;
        bus.out_data  <= zhi;
        bus.out_is_hi <= 1'b1;
      end else begin
        state         <= ST_IDLE;
        bus.out_valid <= 1'b0;
        bus.out_is_hi <= 1'b0;
      end
    end
  end

`ifdef Z_FLAGS_EN
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
    end else if (capture) begin
      if (cap_two) begin
        flag_zero <= (bus.c_in == '0);
        flag_neg  <= bus.c_in[2*DATA_W-1];
      end else begin
        flag_zero <= (zlo_next == '0);
        flag_neg  <= zlo_next[DATA_W-1];
      end
    end
  end
`else
  assign flag_zero = 1'b0;
  assign flag_neg  = 1'b0;
`endif

endmodule
